// File: rtl/text_buffer_ctrl.sv
// Character-grid text buffer with cursor engine, scroll/clear sequencer,
// one-entry event buffer and a registered display read port.
module text_buffer_ctrl #(
   parameter int unsigned GRID_COL = 10,
   parameter int unsigned GRID_ROW = 5,
   parameter int unsigned COL_W    = 4,
   parameter int unsigned ROW_W    = 3
) (
   input  logic             clk_pix,
   input  logic             rst_pix,
   input  logic [6:0]       ascii_in,
   input  logic             write_en,
   input  logic             ctrl_en,
   input  logic [COL_W-1:0] rd_col,
   input  logic [ROW_W-1:0] rd_row,
   output logic [6:0]       rd_char,
   output logic [COL_W-1:0] cur_col,
   output logic [ROW_W-1:0] cur_row,
   output logic             busy,
   output logic             drop
);

   localparam int unsigned N      = GRID_COL * GRID_ROW;
   localparam int unsigned ADDR_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [6:0] SPACE    = 7'h20;
   localparam logic [6:0] PRINT_HI = 7'h7E;
   localparam logic [6:0] CH_BS    = 7'h08;
   localparam logic [6:0] CH_CR    = 7'h0D;
   localparam logic [6:0] CH_FF    = 7'h0C;

   localparam logic [COL_W-1:0]  LAST_COL      = COL_W'(GRID_COL - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW      = ROW_W'(GRID_ROW - 1);
   localparam logic [ADDR_W-1:0] COL_STRIDE    = ADDR_W'(GRID_COL);
   localparam logic [ADDR_W-1:0] SCROLL_END    = ADDR_W'(N - GRID_COL - 1);
   localparam logic [ADDR_W-1:0] CLR_ROW_START = ADDR_W'(N - GRID_COL);
   localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(N - 1);

   typedef enum logic [1:0] {IDLE, SCROLL, CLR_ROW, CLR_ALL} state_t;

   state_t             state_q, state_n;
   logic [ADDR_W-1:0]  idx_q, idx_n;
   logic [COL_W-1:0]   col_n;
   logic [ROW_W-1:0]   row_n;
   logic               pend_valid_q, pend_valid_n;
   logic [6:0]         pend_ascii_q, pend_ascii_n;
   logic               pend_ctrl_q, pend_ctrl_n;
   logic               drop_n;

   logic               mem_we;
   logic [ADDR_W-1:0]  mem_waddr;
   logic [6:0]         mem_wdata;
   logic [6:0]         mem [N];

   logic               ev_valid;
   logic [6:0]         ev_ascii;
   logic               ev_ctrl;
   logic               adv_row;
   logic               rd_in_range;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
      return ADDR_W'(r) * COL_STRIDE + ADDR_W'(c);
   endfunction

   // State, cursor, pending entry and status registers
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         state_q      <= CLR_ALL;
         idx_q        <= '0;
         cur_col      <= '0;
         cur_row      <= '0;
         pend_valid_q <= 1'b0;
         pend_ascii_q <= '0;
         pend_ctrl_q  <= 1'b0;
         drop         <= 1'b0;
         busy         <= 1'b1;
      end else begin
         state_q      <= state_n;
         idx_q        <= idx_n;
         cur_col      <= col_n;
         cur_row      <= row_n;
         pend_valid_q <= pend_valid_n;
         pend_ascii_q <= pend_ascii_n;
         pend_ctrl_q  <= pend_ctrl_n;
         drop         <= drop_n;
         busy         <= (state_n != IDLE);
      end
   end

   // Event decode, buffering and scroll/clear sequencing
   always_comb begin
      state_n      = state_q;
      idx_n        = idx_q;
      col_n        = cur_col;
      row_n        = cur_row;
      pend_valid_n = pend_valid_q;
      pend_ascii_n = pend_ascii_q;
      pend_ctrl_n  = pend_ctrl_q;
      drop_n       = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = idx_q;
      mem_wdata    = SPACE;
      ev_valid     = 1'b0;
      ev_ascii     = ascii_in;
      ev_ctrl      = ctrl_en;
      adv_row      = 1'b0;

      case (state_q)
         IDLE: begin
            // A pending entry always goes first; a same-cycle strobe takes its slot
            if (pend_valid_q) begin
               ev_valid     = 1'b1;
               ev_ascii     = pend_ascii_q;
               ev_ctrl      = pend_ctrl_q;
               pend_valid_n = write_en;
               if (write_en) begin
                  pend_ascii_n = ascii_in;
                  pend_ctrl_n  = ctrl_en;
               end
            end else if (write_en) begin
               ev_valid = 1'b1;
            end

            if (ev_valid) begin
               if (!ev_ctrl && (ev_ascii >= SPACE) && (ev_ascii <= PRINT_HI)) begin
                  mem_we    = 1'b1;
                  mem_waddr = addr_of(cur_row, cur_col);
                  mem_wdata = ev_ascii;
                  if (cur_col == LAST_COL) begin
                     col_n   = '0;
                     adv_row = 1'b1;
                  end else begin
                     col_n = cur_col + COL_W'(1);
                  end
               end else if (ev_ctrl) begin
                  case (ev_ascii)
                     CH_CR: begin
                        col_n   = '0;
                        adv_row = 1'b1;
                     end
                     CH_BS: begin
                        if (cur_col != '0) begin
                           col_n     = cur_col - COL_W'(1);
                           mem_we    = 1'b1;
                           mem_waddr = addr_of(cur_row, cur_col - COL_W'(1));
                        end else if (cur_row != '0) begin
                           row_n     = cur_row - ROW_W'(1);
                           col_n     = LAST_COL;
                           mem_we    = 1'b1;
                           mem_waddr = addr_of(cur_row - ROW_W'(1), LAST_COL);
                        end
                     end
                     CH_FF: begin
                        col_n   = '0;
                        row_n   = '0;
                        idx_n   = '0;
                        state_n = CLR_ALL;
                     end
                     default: ;
                  endcase
               end

               if (adv_row) begin
                  if (cur_row == LAST_ROW) begin
                     idx_n   = '0;
                     state_n = SCROLL;
                  end else begin
                     row_n = cur_row + ROW_W'(1);
                  end
               end
            end
         end
         SCROLL: begin
            mem_we    = 1'b1;
            mem_wdata = mem[idx_q + COL_STRIDE];
            if (idx_q == SCROLL_END) begin
               idx_n   = CLR_ROW_START;
               state_n = CLR_ROW;
            end else begin
               idx_n = idx_q + ADDR_W'(1);
            end
         end
         CLR_ROW, CLR_ALL: begin
            mem_we = 1'b1;
            if (idx_q == LAST_ADDR) begin
               idx_n   = '0;
               state_n = IDLE;
            end else begin
               idx_n = idx_q + ADDR_W'(1);
            end
         end
         default: state_n = CLR_ALL;
      endcase

      // Events arriving while busy fill the single slot or are lost
      if ((state_q != IDLE) && write_en) begin
         if (pend_valid_q) begin
            drop_n = 1'b1;
         end else begin
            pend_valid_n = 1'b1;
            pend_ascii_n = ascii_in;
            pend_ctrl_n  = ctrl_en;
         end
      end
   end

   // Character memory write port
   always_ff @(posedge clk_pix) begin
      if (!rst_pix && mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign rd_in_range = (32'(rd_col) < GRID_COL) && (32'(rd_row) < GRID_ROW);

   // Display read port, one cycle latency, blanks outside the grid
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         rd_char <= SPACE;
      end else if (rd_in_range) begin
         rd_char <= mem[addr_of(rd_row, rd_col)];
      end else begin
         rd_char <= SPACE;
      end
   end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl with an event-level grid/cursor model
// and a queue of expected display-read values.
module tb_text_buffer_ctrl;

   localparam int GC = 10;
   localparam int GR = 5;
   localparam int N  = GC * GR;

   logic       clk_pix = 1'b0;
   logic       rst_pix;
   logic [6:0] ascii_in;
   logic       write_en;
   logic       ctrl_en;
   logic [3:0] rd_col;
   logic [2:0] rd_row;
   logic [6:0] rd_char;
   logic [3:0] cur_col;
   logic [2:0] cur_row;
   logic       busy;
   logic       drop;

   int checks = 0;
   int errors = 0;
   int busy_total = 0;
   int drop_total = 0;
   int b0, d0;

   logic [6:0] exp_q [$];
   logic [6:0] model [N];
   int mc, mr;

   text_buffer_ctrl #(.GRID_COL(GC), .GRID_ROW(GR), .COL_W(4), .ROW_W(3)) dut (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .ascii_in(ascii_in),
      .write_en(write_en), .ctrl_en(ctrl_en), .rd_col(rd_col), .rd_row(rd_row),
      .rd_char(rd_char), .cur_col(cur_col), .cur_row(cur_row),
      .busy(busy), .drop(drop)
   );

   always #5 clk_pix = ~clk_pix;

   // Busy-cycle and drop-pulse counters, sampled mid-cycle
   always @(negedge clk_pix) begin
      if (busy === 1'b1) busy_total = busy_total + 1;
      if (drop === 1'b1) drop_total = drop_total + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) model[i] = 7'h20;
   endtask

   task automatic model_adv_row();
      if (mr == GR - 1) begin
         for (int i = 0; i < N - GC; i++) model[i] = model[i + GC];
         for (int i = N - GC; i < N; i++) model[i] = 7'h20;
      end else begin
         mr++;
      end
   endtask

   task automatic model_event(input logic [6:0] a, input logic c);
      if (!c && a >= 7'h20 && a <= 7'h7E) begin
         model[mr * GC + mc] = a;
         if (mc == GC - 1) begin
            mc = 0;
            model_adv_row();
         end else begin
            mc++;
         end
      end else if (c && a == 7'h0D) begin
         mc = 0;
         model_adv_row();
      end else if (c && a == 7'h08) begin
         if (mc > 0) begin
            mc--;
            model[mr * GC + mc] = 7'h20;
         end else if (mr > 0) begin
            mr--;
            mc = GC - 1;
            model[mr * GC + mc] = 7'h20;
         end
      end else if (c && a == 7'h0C) begin
         mc = 0;
         mr = 0;
         model_clear();
      end
   endtask

   task automatic send(input logic [6:0] a, input logic c);
      ascii_in = a;
      ctrl_en  = c;
      write_en = 1'b1;
      tick();
      write_en = 1'b0;
      ctrl_en  = 1'b0;
      ascii_in = 7'h00;
   endtask

   task automatic typ(input logic [6:0] a, input logic c);
      send(a, c);
      model_event(a, c);
   endtask

   task automatic read_cell(input int c, input int r);
      rd_col = 4'(c);
      rd_row = 3'(r);
      if (c < GC && r < GR) exp_q.push_back(model[r * GC + c]);
      else                  exp_q.push_back(7'h20);
      tick();
      check($sformatf("rd_char(%0d,%0d)", c, r), 32'(rd_char), 32'(exp_q.pop_front()));
   endtask

   task automatic check_grid();
      for (int r = 0; r < GR; r++)
         for (int c = 0; c < GC; c++)
            read_cell(c, r);
   endtask

   task automatic check_cur(input string tag);
      check({tag, "_col"}, 32'(cur_col), 32'(mc));
      check({tag, "_row"}, 32'(cur_row), 32'(mr));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      check("idle_reached", 32'(busy), 32'(0));
   endtask

   initial begin
      rst_pix  = 1'b1;
      write_en = 1'b0;
      ctrl_en  = 1'b0;
      ascii_in = 7'h00;
      rd_col   = '0;
      rd_row   = '0;
      mc = 0;
      mr = 0;
      model_clear();

      // Reset state and initial clear
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'(1));
      check("rst_drop", 32'(drop), 32'(0));
      check("rst_rd_char", 32'(rd_char), 32'(7'h20));
      check_cur("rst_cur");
      b0 = busy_total;
      rst_pix = 1'b0;
      wait_idle();
      check("reset_clear_cycles", 32'(busy_total - b0), 32'(N));
      check_grid();
      check_cur("post_clear");

      // No-ops: backspace at origin, ignored codes
      typ(7'h08, 1'b1);
      check_cur("bs_origin");
      typ(7'h07, 1'b0);
      typ(7'h41, 1'b1);
      typ(7'h7F, 1'b0);
      check_cur("ignored");
      check("ignored_busy", 32'(busy), 32'(0));
      check("ignored_drops", 32'(drop_total), 32'(0));
      read_cell(0, 0);

      // Type "AB"
      typ(7'h41, 1'b0);
      check_cur("after_A");
      read_cell(0, 0);
      typ(7'h42, 1'b0);
      check_cur("after_B");
      read_cell(0, 0);
      read_cell(1, 0);

      // Finish row 0, wrap, enter, backspace across rows
      for (int i = 0; i < 8; i++) typ(7'(8'h43 + i), 1'b0);
      check_cur("row0_wrap");
      typ(7'h0D, 1'b1);
      check_cur("enter");
      typ(7'h08, 1'b1);
      check_cur("bs_rowback");
      read_cell(9, 1);
      typ(7'h51, 1'b0);
      check_cur("q_wrap");
      read_cell(9, 1);
      typ(7'h08, 1'b1);
      check_cur("bs_erase");
      read_cell(9, 1);

      // Fill to the last row and scroll off the end
      typ(7'h0D, 1'b1);
      for (int i = 0; i < 10; i++) typ(7'(8'h30 + i), 1'b0);
      typ(7'h0D, 1'b1);
      check_cur("at_last_row");
      for (int i = 0; i < 9; i++) typ(7'(8'h61 + i), 1'b0);
      check("pre_scroll_busy", 32'(busy), 32'(0));
      b0 = busy_total;
      typ(7'h6A, 1'b0);
      check("scroll_busy", 32'(busy), 32'(1));
      check_cur("scroll_cur");
      wait_idle();
      check("scroll_cycles", 32'(busy_total - b0), 32'(N));
      check_cur("post_scroll");
      check_grid();

      // Out-of-range reads return blanks
      read_cell(12, 2);
      read_cell(10, 3);
      read_cell(0, 7);

      // Strobes during a scroll: one held, two dropped
      d0 = drop_total;
      b0 = busy_total;
      typ(7'h0D, 1'b1);
      tick();
      tick();
      send(7'h50, 1'b0);
      check("pend_store_drop", 32'(drop), 32'(0));
      tick();
      send(7'h78, 1'b0);
      check("drop_2nd", 32'(drop), 32'(1));
      tick();
      check("drop_pulse_end", 32'(drop), 32'(0));
      send(7'h79, 1'b0);
      check("drop_3rd", 32'(drop), 32'(1));
      tick();
      check("drop_pulse_end2", 32'(drop), 32'(0));
      wait_idle();
      check("scroll2_cycles", 32'(busy_total - b0), 32'(N));
      check("scroll2_drops", 32'(drop_total - d0), 32'(2));
      check_cur("scroll2_hold");
      // First idle cycle: pending executes while a new strobe is stored
      send(7'h52, 1'b0);
      model_event(7'h50, 1'b0);
      check("first_idle_drop", 32'(drop), 32'(0));
      check_cur("pend_exec");
      tick();
      model_event(7'h52, 1'b0);
      check_cur("pend2_exec");
      check("total_drops", 32'(drop_total - d0), 32'(2));
      read_cell(0, 4);
      read_cell(1, 4);

      // Clear screen mid-text
      typ(7'h5A, 1'b0);
      b0 = busy_total;
      typ(7'h0C, 1'b1);
      check("clear_busy", 32'(busy), 32'(1));
      check_cur("clear_cur");
      wait_idle();
      check("clear_cycles", 32'(busy_total - b0), 32'(N));
      check_grid();

      // Reset in the middle of a scroll with an event pending
      for (int i = 0; i < 4; i++) typ(7'h0D, 1'b1);
      typ(7'h0D, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      send(7'h4B, 1'b0);
      d0 = drop_total;
      tick();
      rst_pix = 1'b1;
      tick();
      b0 = busy_total;
      mc = 0;
      mr = 0;
      model_clear();
      check("midrst_busy", 32'(busy), 32'(1));
      check("midrst_drop", 32'(drop), 32'(0));
      check_cur("midrst_cur");
      rst_pix = 1'b0;
      wait_idle();
      check("midrst_clear_cycles", 32'(busy_total - b0), 32'(N));
      tick();
      tick();
      tick();
      check_cur("midrst_no_pend");
      check("midrst_no_drop", 32'(drop_total - d0), 32'(0));
      check_grid();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
